regfile_wb_seq: RTL and testbench

- Writeback sequencer that sits directly upstream of the split-half register file.
- Accepts one 32-bit writeback result per handshake, applies load-size extension (byte/half/word/bit) and drives the register file's 16-bit write port over two consecutive cycles, one half per cycle.
- Extension logic lives here, not in the register file, so loads, ALU results and compares share one path.
- Also exports the in-flight destination so the issue stage can stall on read-after-write hazards.

---
 rtl/regfile_wb_seq_if.sv | 33 +++
 rtl/regfile_wb_seq.sv | 105 ++++++++++
 tb/tb_regfile_wb_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_seq_if.sv
// rtl/regfile_wb_seq_if.sv - request/regfile-write bundle for the writeback sequencer
// The package carries the load-size and extension encodings shared by both sides.
package regfile_wb_seq_pkg;
  typedef enum logic [1:0] {SIZE_W, SIZE_H, SIZE_B, SIZE_BIT} cs_size;
  typedef enum logic {EXT_Z, EXT_S} cs_ext;
endpackage

interface regfile_wb_seq_if;
  import regfile_wb_seq_pkg::*;

  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_i;
  logic [31:0] data_i;
  cs_size      size_i;
  cs_ext       ext_i;
  logic        write_o;
  logic [4:0]  rd_o;
  logic        rd_h_sel_o;
  logic [15:0] write_data_o;
  logic        pend_o;
  logic [4:0]  pend_rd_o;

  modport master (
    output valid_i, rd_i, data_i, size_i, ext_i,
    input  ready_o, write_o, rd_o, rd_h_sel_o, write_data_o, pend_o, pend_rd_o
  );

  modport slave (
    input  valid_i, rd_i, data_i, size_i, ext_i,
    output ready_o, write_o, rd_o, rd_h_sel_o, write_data_o, pend_o, pend_rd_o
  );
endinterface

// File: rtl/regfile_wb_seq.sv
// rtl/regfile_wb_seq.sv - extends a 32-bit writeback result and writes it as two 16-bit halves
// Outputs decode only registered state, so the issue stage sees no path from valid_i.
module regfile_wb_seq
  import regfile_wb_seq_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  regfile_wb_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;

  state_t      state, state_d;
  logic [4:0]  rd_q;
  logic [15:0] lo_q, hi_q;
  logic [15:0] lo_d, hi_d;
  logic        ready;
  logic        accept;
  logic        s;

  always_comb begin
    lo_d = 16'h0;
    hi_d = 16'h0;
    s    = (bus.ext_i == EXT_S);
    case (bus.size_i)
      SIZE_W: begin
        lo_d = bus.data_i[15:0];
        hi_d = bus.data_i[31:16];
      end
      SIZE_H: begin
        lo_d = bus.data_i[15:0];
        hi_d = {16{s & bus.data_i[15]}};
      end
      SIZE_B: begin
        lo_d = {{8{s & bus.data_i[7]}}, bus.data_i[7:0]};
        hi_d = {16{s & bus.data_i[7]}};
      end
      default: begin
        lo_d = {15'b0, bus.data_i[0]};
        hi_d = 16'h0;
      end
    endcase
  end

  // WR_B also accepts, giving back-to-back requests one write per cycle.
  always_comb begin
    state_d = state;
    ready   = (state == IDLE) || (state == WR_B);
    accept  = ready && bus.valid_i;
    case (state)
      IDLE:    state_d = accept ? WR_A : IDLE;
      WR_A:    state_d = WR_B;
      WR_B:    state_d = accept ? WR_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_q  <= 5'd0;
      lo_q  <= 16'h0;
      hi_q  <= 16'h0;
    end else begin
      state <= state_d;
      if (accept) begin
        rd_q <= bus.rd_i;
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
    end
  end

  always_comb begin
    bus.ready_o      = ready;
    bus.pend_o       = 1'b0;
    bus.pend_rd_o    = 5'd0;
    bus.write_o      = 1'b0;
    bus.rd_o         = 5'd0;
    bus.rd_h_sel_o   = 1'b0;
    bus.write_data_o = 16'h0;
    case (state)
      WR_A: begin
        bus.pend_o       = 1'b1;
        bus.pend_rd_o    = rd_q;
        bus.write_o      = (rd_q != 5'd0);
        bus.rd_o         = rd_q;
        bus.rd_h_sel_o   = ~LO_FIRST;
        bus.write_data_o = LO_FIRST ? lo_q : hi_q;
      end
      WR_B: begin
        bus.pend_o       = 1'b1;
        bus.pend_rd_o    = rd_q;
        bus.write_o      = (rd_q != 5'd0);
        bus.rd_o         = rd_q;
        bus.rd_h_sel_o   = LO_FIRST;
        bus.write_data_o = LO_FIRST ? hi_q : lo_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_wb_seq.sv
// tb/tb_regfile_wb_seq.sv - directed bench for regfile_wb_seq, both half orders
module tb_regfile_wb_seq;
  import regfile_wb_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_seq_if bus_a ();
  regfile_wb_seq_if bus_b ();

  regfile_wb_seq #(.LO_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_wb_seq #(.LO_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // {write, rd, h_sel, data, pend, pend_rd, ready}
  localparam logic [29:0] IDLE_OBS = {1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 5'd0, 1'b1};

  function automatic logic [29:0] obs_a();
    return {bus_a.write_o, bus_a.rd_o, bus_a.rd_h_sel_o, bus_a.write_data_o,
            bus_a.pend_o, bus_a.pend_rd_o, bus_a.ready_o};
  endfunction

  function automatic logic [29:0] obs_b();
    return {bus_b.write_o, bus_b.rd_o, bus_b.rd_h_sel_o, bus_b.write_data_o,
            bus_b.pend_o, bus_b.pend_rd_o, bus_b.ready_o};
  endfunction

  function automatic logic [29:0] wr(input logic w, input logic [4:0] rd,
                                     input logic sel, input logic [15:0] d, input logic rdy);
    return {w, rd, sel, d, 1'b1, rd, rdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the chosen bus for one edge; returns with the DUT in WR_A.
  task automatic send(input bit use_b, input logic [4:0] rd, input logic [31:0] d,
                      input cs_size sz, input cs_ext ex);
    if (use_b) begin
      bus_b.rd_i = rd; bus_b.data_i = d; bus_b.size_i = sz; bus_b.ext_i = ex; bus_b.valid_i = 1'b1;
    end else begin
      bus_a.rd_i = rd; bus_a.data_i = d; bus_a.size_i = sz; bus_a.ext_i = ex; bus_a.valid_i = 1'b1;
    end
    tick();
    bus_a.valid_i = 1'b0;
    bus_b.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] exp;
    rst_n = 1'b0;
    tick();
    tick();
    exp = IDLE_OBS;
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL reset_a got %h want %h", obs_a(), exp); end
    checks++;
    if (obs_b() !== exp) begin errors++; $display("FAIL reset_b got %h want %h", obs_b(), exp); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL post_reset got %h want %h", obs_a(), exp); end
  endtask

  task automatic test_word();
    logic [29:0] exp;
    send(1'b0, 5'd5, 32'hDEAD_BEEF, SIZE_W, EXT_Z);
    exp = wr(1'b1, 5'd5, 1'b0, 16'hBEEF, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL word_lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd5, 1'b1, 16'hDEAD, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL word_hi got %h want %h", obs_a(), exp); end
    tick();
    exp = IDLE_OBS;
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL word_idle got %h want %h", obs_a(), exp); end
  endtask

  task automatic test_byte();
    logic [29:0] exp;
    send(1'b0, 5'd3, 32'h1234_5680, SIZE_B, EXT_S);
    exp = wr(1'b1, 5'd3, 1'b0, 16'hFF80, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL byte_s_lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd3, 1'b1, 16'hFFFF, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL byte_s_hi got %h want %h", obs_a(), exp); end
    tick();
    send(1'b0, 5'd3, 32'h1234_5680, SIZE_B, EXT_Z);
    exp = wr(1'b1, 5'd3, 1'b0, 16'h0080, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL byte_z_lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd3, 1'b1, 16'h0000, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL byte_z_hi got %h want %h", obs_a(), exp); end
    tick();
  endtask

  task automatic test_half_bit();
    logic [29:0] exp;
    send(1'b0, 5'd7, 32'h0000_8001, SIZE_H, EXT_S);
    exp = wr(1'b1, 5'd7, 1'b0, 16'h8001, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL half_lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd7, 1'b1, 16'hFFFF, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL half_hi got %h want %h", obs_a(), exp); end
    tick();
    send(1'b0, 5'd7, 32'hFFFF_FFFE, SIZE_BIT, EXT_S);
    exp = wr(1'b1, 5'd7, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL bit_lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd7, 1'b1, 16'h0000, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL bit_hi got %h want %h", obs_a(), exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp;
    checks++;
    if (bus_a.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", bus_a.ready_o); end
    bus_a.rd_i = 5'd1; bus_a.data_i = 32'h1111_2222; bus_a.size_i = SIZE_W; bus_a.ext_i = EXT_Z;
    bus_a.valid_i = 1'b1;
    tick();
    exp = wr(1'b1, 5'd1, 1'b0, 16'h2222, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL b2b_1lo got %h want %h", obs_a(), exp); end
    bus_a.rd_i = 5'd2; bus_a.data_i = 32'h3333_4444;
    tick();
    exp = wr(1'b1, 5'd1, 1'b1, 16'h1111, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL b2b_1hi got %h want %h", obs_a(), exp); end
    tick();
    bus_a.valid_i = 1'b0;
    exp = wr(1'b1, 5'd2, 1'b0, 16'h4444, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL b2b_2lo got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b1, 5'd2, 1'b1, 16'h3333, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL b2b_2hi got %h want %h", obs_a(), exp); end
    tick();
    exp = IDLE_OBS;
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL b2b_idle got %h want %h", obs_a(), exp); end
  endtask

  task automatic test_rd0_lo_first0();
    logic [29:0] exp;
    send(1'b0, 5'd0, 32'h0000_1234, SIZE_W, EXT_Z);
    exp = wr(1'b0, 5'd0, 1'b0, 16'h1234, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL rd0_a got %h want %h", obs_a(), exp); end
    tick();
    exp = wr(1'b0, 5'd0, 1'b1, 16'h0000, 1'b1);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL rd0_b got %h want %h", obs_a(), exp); end
    tick();
    send(1'b1, 5'd9, 32'hA5A5_0F0F, SIZE_W, EXT_Z);
    exp = wr(1'b1, 5'd9, 1'b1, 16'hA5A5, 1'b0);
    checks++;
    if (obs_b() !== exp) begin errors++; $display("FAIL hifirst_a got %h want %h", obs_b(), exp); end
    tick();
    exp = wr(1'b1, 5'd9, 1'b0, 16'h0F0F, 1'b1);
    checks++;
    if (obs_b() !== exp) begin errors++; $display("FAIL hifirst_b got %h want %h", obs_b(), exp); end
    tick();
    exp = IDLE_OBS;
    checks++;
    if (obs_b() !== exp) begin errors++; $display("FAIL hifirst_idle got %h want %h", obs_b(), exp); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] exp;
    send(1'b0, 5'd12, 32'hCAFE_F00D, SIZE_W, EXT_Z);
    exp = wr(1'b1, 5'd12, 1'b0, 16'hF00D, 1'b0);
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL mid_first got %h want %h", obs_a(), exp); end
    rst_n = 1'b0;
    tick();
    exp = IDLE_OBS;
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL mid_reset got %h want %h", obs_a(), exp); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_a() !== exp) begin errors++; $display("FAIL mid_no_second got %h want %h", obs_a(), exp); end
  endtask

  initial begin
    bus_a.valid_i = 1'b0; bus_a.rd_i = 5'd0; bus_a.data_i = 32'h0;
    bus_a.size_i = SIZE_W; bus_a.ext_i = EXT_Z;
    bus_b.valid_i = 1'b0; bus_b.rd_i = 5'd0; bus_b.data_i = 32'h0;
    bus_b.size_i = SIZE_W; bus_b.ext_i = EXT_Z;
    test_reset();
    test_word();
    test_byte();
    test_half_bit();
    test_back_to_back();
    test_rd0_lo_first0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
